// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and defaults for the two-requester multiplier-sharing arbiter.
package mul_share_arbiter_pkg;

  localparam int unsigned WDefault       = 8;
  localparam int unsigned TimeoutDefault = 64;
  localparam int unsigned WdogW          = $clog2(TimeoutDefault);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; prefers the requester that did not win last time.
module rr_arb2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_grant_i,
  input  logic       enable_i,
  output logic [1:0] grant_o,
  output logic       grant_id_o
);

  logic any_valid;

  always_comb begin
    grant_id_o = 1'b0;
    if (valid0_i && valid1_i) begin
      grant_id_o = ~last_grant_i;
    end else if (valid1_i) begin
      grant_id_o = 1'b1;
    end
    any_valid = valid0_i | valid1_i;
    grant_o   = {grant_id_o, ~grant_id_o} & {2{enable_i & any_valid}};
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one sequential Booth multiplier between two requesters: arbitrates, starts the unit,
// reassembles the {hi, lo} product and returns it over a valid/ready response, with a watchdog.
module mul_share_arbiter
  import mul_share_arbiter_pkg::*;
#(
  parameter int unsigned W       = WDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*W-1:0] rsp_data,
  output logic           rsp_err,
  output logic           mul_bgn,
  output logic [W-1:0]   mul_x,
  output logic [W-1:0]   mul_y,
  input  logic           mul_c6,
  input  logic           mul_c7,
  input  logic [W-1:0]   mul_outbus,
  input  logic           mul_done
);

  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  state_e         state_q;
  logic           last_grant_q;
  logic [WdW-1:0] wdog_q;
  logic [WdW-1:0] wdog_nxt;
  logic [W-1:0]   hi_q, lo_q, x_q, y_q;
  logic           bgn_q, rsp_valid_q, rsp_id_q, rsp_err_q;

  logic [1:0]     grant;
  logic           grant_id;
  logic           accept;
  logic [W-1:0]   acc_a, acc_b;

  // Readies are forced low while reset is asserted so every output reads 0 during reset.
  rr_arb2 u_arb (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant_q),
    .enable_i     ((state_q == StIdle) && rst_b),
    .grant_o      (grant),
    .grant_id_o   (grant_id)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;
  assign acc_a      = grant_id ? req1_a : req0_a;
  assign acc_b      = grant_id ? req1_b : req0_b;
  assign wdog_nxt   = wdog_q + 1'b1;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      wdog_q       <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      bgn_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            x_q          <= acc_a;
            y_q          <= acc_b;
            rsp_id_q     <= grant_id;
            last_grant_q <= grant_id;
            hi_q         <= '0;
            lo_q         <= '0;
            wdog_q       <= '0;
            rsp_err_q    <= 1'b0;
            bgn_q        <= 1'b1;
            state_q      <= StStart;
          end
        end
        StStart: begin
          bgn_q   <= 1'b0;
          state_q <= StWait;
        end
        StWait: begin
          wdog_q <= wdog_nxt;
          if (mul_c6) hi_q <= mul_outbus;
          if (mul_c7) lo_q <= mul_outbus;
          // Done wins over a simultaneous timeout; a timeout discards any partial product.
          if (mul_done) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            state_q     <= StResp;
          end else if (wdog_nxt == WdLast) begin
            hi_q        <= '0;
            lo_q        <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = {hi_q, lo_q};
  assign mul_bgn   = bgn_q;
  assign mul_x     = x_q;
  assign mul_y     = y_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural 12-cycle multiplier model.
module tb_mul_share_arbiter;

  localparam int unsigned W       = 8;
  localparam int unsigned TIMEOUT = 64;
  localparam int          LatNom  = 15;

  logic           clk = 1'b0;
  logic           rst_b = 1'b0;
  logic           req0_valid = 1'b0, req1_valid = 1'b0;
  logic           req0_ready, req1_ready;
  logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic           rsp_valid, rsp_id, rsp_err;
  logic           rsp_ready = 1'b0;
  logic [2*W-1:0] rsp_data;
  logic           mul_bgn, mul_c6, mul_c7, mul_done;
  logic [W-1:0]   mul_x, mul_y, mul_outbus;

  logic           m_done, m_c6, m_c7, m_busy;
  logic [W-1:0]   m_bus;
  logic [2*W-1:0] m_prod;
  int             m_cnt;
  bit             hang = 1'b0;
  logic           inj_done = 1'b0, inj_c6 = 1'b0, inj_c7 = 1'b0;
  logic [W-1:0]   inj_bus = '0;

  int checks = 0;
  int failures = 0;
  int bgn_cnt = 0;
  int rdy_both = 0;
  logic [W-1:0] bgn_x = '0, bgn_y = '0;

  always #5 clk = ~clk;

  assign mul_done   = m_done | inj_done;
  assign mul_c6     = m_c6 | inj_c6;
  assign mul_c7     = m_c7 | inj_c7;
  assign mul_outbus = m_bus | inj_bus;

  mul_share_arbiter #(
    .W       (W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .mul_bgn    (mul_bgn),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_c6     (mul_c6),
    .mul_c7     (mul_c7),
    .mul_outbus (mul_outbus),
    .mul_done   (mul_done)
  );

  // Multiplier model: high half, then low half together with done, 13 cycles after bgn.
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_busy <= 1'b0; m_cnt <= 0; m_done <= 1'b0; m_c6 <= 1'b0; m_c7 <= 1'b0;
      m_bus <= '0; m_prod <= '0;
    end else begin
      m_done <= 1'b0; m_c6 <= 1'b0; m_c7 <= 1'b0; m_bus <= '0;
      if (mul_bgn) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_prod <= {{W{mul_x[W-1]}}, mul_x} * {{W{mul_y[W-1]}}, mul_y};
      end else if (m_busy) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == 10) begin
          m_c6 <= 1'b1; m_bus <= m_prod[2*W-1:W];
        end
        if (m_cnt == 11) begin
          m_c7 <= 1'b1; m_bus <= m_prod[W-1:0]; m_done <= !hang; m_busy <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mul_bgn) begin
      bgn_cnt <= bgn_cnt + 1; bgn_x <= mul_x; bgn_y <= mul_y;
    end
    if (req0_ready && req1_ready) rdy_both <= rdy_both + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic set_req(input bit id, input bit v, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b;
    end
  endtask

  task automatic wait_grant(input bit id, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 40) begin
      if (id ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk); #1;
      lat++;
    end while (!rsp_valid && lat < 200);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
  endtask

  task automatic run_txn(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         output bit ok, output int lat, output logic rid,
                         output logic [2*W-1:0] rdata, output logic rerr);
    @(negedge clk);
    set_req(id, 1'b1, a, b);
    #1;
    wait_grant(id, ok);
    lat = 0; rid = 1'b0; rdata = '0; rerr = 1'b0;
    if (ok) begin
      @(posedge clk); #1;
      set_req(id, 1'b0, a, b);
      wait_rsp(lat);
      ok = rsp_valid; rid = rsp_id; rdata = rsp_data; rerr = rsp_err;
      handshake();
    end else begin
      set_req(id, 1'b0, a, b);
    end
  endtask

  typedef struct {
    bit             id;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[7];
    bit ok;
    int lat, b0, stable_bad, extra_rdy;
    logic rid, rerr, g;
    logic [2*W-1:0] rdata, d0;

    vecs[0] = '{1'b0, 8'h03, 8'h05, 16'h000F};
    vecs[1] = '{1'b1, 8'hFD, 8'h07, 16'hFFEB};
    vecs[2] = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[3] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vecs[4] = '{1'b0, 8'hFF, 8'h01, 16'hFFFF};
    vecs[5] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    vecs[6] = '{1'b0, 8'h00, 8'h55, 16'h0000};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_bgn", mul_bgn, 0);
    chk("reset_xy", {mul_x, mul_y}, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_id_err", {rsp_id, rsp_err}, 0);
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    chk("post_reset_ready", {req1_ready, req0_ready}, 0);

    // Contention: both held valid, grants alternate starting with req0
    @(negedge clk);
    set_req(1'b0, 1'b1, 8'h02, 8'h03);
    set_req(1'b1, 1'b1, 8'h04, 8'h05);
    #1;
    for (int t = 0; t < 4; t++) begin
      int n = 0;
      while (!(req0_ready || req1_ready) && n < 40) begin
        @(negedge clk); #1;
        n++;
      end
      chk("cont_ready_seen", n < 40, 1);
      g = req1_ready;
      chk("cont_grant_order", g, t % 2);
      @(posedge clk); #1;
      wait_rsp(lat);
      chk("cont_rsp_id", rsp_id, g);
      chk("cont_rsp_data", rsp_data, g ? 16'd20 : 16'd6);
      handshake();
    end
    set_req(1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 8'h00, 8'h00);
    chk("cont_ready_exclusive", rdy_both, 0);

    // Table-driven single transactions
    for (int i = 0; i < 7; i++) begin
      b0 = bgn_cnt;
      run_txn(vecs[i].id, vecs[i].a, vecs[i].b, ok, lat, rid, rdata, rerr);
      chk($sformatf("vec%0d_ok", i), ok, 1);
      chk($sformatf("vec%0d_data", i), rdata, vecs[i].exp);
      chk($sformatf("vec%0d_id", i), rid, vecs[i].id);
      chk($sformatf("vec%0d_err", i), rerr, 0);
      chk($sformatf("vec%0d_latency", i), lat, LatNom);
      chk($sformatf("vec%0d_bgn_pulses", i), bgn_cnt - b0, 1);
      chk($sformatf("vec%0d_mul_xy", i), {bgn_x, bgn_y}, {vecs[i].a, vecs[i].b});
    end

    // Backpressure: response held for 10 cycles while req0 waits
    @(negedge clk);
    set_req(1'b1, 1'b1, 8'h06, 8'hFA);
    #1;
    wait_grant(1'b1, ok);
    chk("bp_grant", ok, 1);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 8'h06, 8'hFA);
    set_req(1'b0, 1'b1, 8'h09, 8'h09);
    wait_rsp(lat);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_rsp_data", rsp_data, 16'hFFDC);
    chk("bp_rsp_id", rsp_id, 1);
    d0 = rsp_data;
    stable_bad = 0;
    extra_rdy = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (!rsp_valid || rsp_data !== d0 || rsp_id !== 1'b1 || rsp_err !== 1'b0) stable_bad++;
      if (req0_ready || req1_ready) extra_rdy++;
    end
    chk("bp_stable", stable_bad, 0);
    chk("bp_no_ready", extra_rdy, 0);
    handshake();
    chk("bp_resume_ready", req0_ready, 1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 8'h09, 8'h09);
    wait_rsp(lat);
    chk("bp_next_data", rsp_data, 16'h0051);
    chk("bp_next_latency", lat, LatNom);
    handshake();

    // Watchdog: multiplier never signals done
    hang = 1'b1;
    @(negedge clk);
    set_req(1'b0, 1'b1, 8'h11, 8'h22);
    #1;
    wait_grant(1'b0, ok);
    chk("wd_grant", ok, 1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 8'h11, 8'h22);
    wait_rsp(lat);
    chk("wd_latency", lat, TIMEOUT + 1);
    chk("wd_err", rsp_err, 1);
    chk("wd_data", rsp_data, 0);
    chk("wd_id", rsp_id, 0);
    inj_done = 1'b1; inj_c6 = 1'b1; inj_c7 = 1'b1; inj_bus = 8'hAA;
    @(negedge clk);
    inj_done = 1'b0; inj_c6 = 1'b0; inj_c7 = 1'b0; inj_bus = '0;
    #1;
    chk("wd_late_done_valid", rsp_valid, 1);
    chk("wd_late_done_data", rsp_data, 0);
    chk("wd_late_done_err", rsp_err, 1);
    handshake();
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    #1;
    chk("idle_done_ignored", {rsp_valid, mul_bgn}, 0);
    hang = 1'b0;

    // Reset in WAIT abandons the operation
    @(negedge clk);
    set_req(1'b1, 1'b1, 8'h05, 8'h05);
    #1;
    wait_grant(1'b1, ok);
    chk("rst_grant", ok, 1);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 8'h05, 8'h05);
    repeat (5) @(negedge clk);
    set_req(1'b0, 1'b1, 8'hF0, 8'h03);
    set_req(1'b1, 1'b1, 8'h01, 8'h01);
    rst_b = 1'b0;
    #1;
    chk("rst_async_xy", {mul_x, mul_y}, 0);
    chk("rst_async_ctrl", {rsp_valid, mul_bgn, rsp_id, rsp_err}, 0);
    chk("rst_async_data", rsp_data, 0);
    chk("rst_async_ready", {req1_ready, req0_ready}, 0);
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    chk("rst_first_grant", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 8'hF0, 8'h03);
    set_req(1'b1, 1'b0, 8'h01, 8'h01);
    wait_rsp(lat);
    chk("rst_next_data", rsp_data, 16'hFFD0);
    chk("rst_next_id", rsp_id, 0);
    chk("rst_next_latency", lat, LatNom);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
